// File: rtl/bounded_down_counter.sv
// Down counter between registered bounds: counts hi->lo, reloads hi with a terminal-count pulse,
// keeps a saturating wrap count and takes new bounds through a valid/ready handshake.
module bounded_down_counter #(
    parameter int DATA_WIDTH          = 32,
    parameter int DEFAULT_UPPER_BOUND = 15,
    parameter int DEFAULT_LOWER_BOUND = 0,
    parameter int WRAP_WIDTH          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DATA_WIDTH-1:0] cfg_lower,
    input  logic [DATA_WIDTH-1:0] cfg_upper,
    output logic                  cfg_error,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  tc,
    output logic [WRAP_WIDTH-1:0] wrap_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CFG  = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] DEF_HI = DATA_WIDTH'(DEFAULT_UPPER_BOUND);
    localparam logic [DATA_WIDTH-1:0] DEF_LO = DATA_WIDTH'(DEFAULT_LOWER_BOUND);

    function automatic logic [WRAP_WIDTH-1:0] sat_inc(input logic [WRAP_WIDTH-1:0] v);
        if (v == {WRAP_WIDTH{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + WRAP_WIDTH'(1'b1);
        end
    endfunction

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   lo_r, lo_s, hi_r, hi_s, out_r, out_s;
    logic [WRAP_WIDTH-1:0]   wrap_r, wrap_s;
    logic                    tc_r, tc_s, err_r, err_s;
    logic                    hs_s, accept_s, reject_s, count_s;

    assign cfg_ready = (state_r != CFG);
    assign hs_s      = cfg_valid & cfg_ready;
    assign accept_s  = hs_s & (cfg_lower <= cfg_upper);
    assign reject_s  = hs_s & (cfg_lower > cfg_upper);
    // The CFG cycle is a settle cycle: no counting while new bounds land.
    assign count_s   = en & (state_r != CFG) & ~accept_s;

    assign out       = out_r;
    assign tc        = tc_r;
    assign cfg_error = err_r;
    assign wrap_cnt  = wrap_r;

    // Next-state selection; an accepted config overrides the enable.
    always_comb begin
        state_s = state_r;
        if (accept_s) begin
            state_s = CFG;
        end else begin
            case (state_r)
                IDLE:    state_s = en ? RUN : IDLE;
                RUN:     state_s = en ? RUN : IDLE;
                CFG:     state_s = en ? RUN : IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Datapath next values: config load, decrement, reload-on-wrap.
    always_comb begin
        lo_s   = lo_r;
        hi_s   = hi_r;
        out_s  = out_r;
        wrap_s = wrap_r;
        tc_s   = 1'b0;
        err_s  = 1'b0;
        if (accept_s) begin
            lo_s   = cfg_lower;
            hi_s   = cfg_upper;
            out_s  = cfg_upper;
            wrap_s = {WRAP_WIDTH{1'b0}};
        end else begin
            err_s = reject_s;
            if (count_s) begin
                if (out_r == lo_r) begin
                    out_s  = hi_r;
                    tc_s   = 1'b1;
                    wrap_s = sat_inc(wrap_r);
                end else if ((out_r > lo_r) && (out_r <= hi_r)) begin
                    out_s = out_r - DATA_WIDTH'(1'b1);
                end else begin
                    // Out-of-range count can only come from a fault; recover silently.
                    out_s = hi_r;
                end
            end else begin
                tc_s = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            lo_r    <= DEF_LO;
            hi_r    <= DEF_HI;
            out_r   <= DEF_HI;
            wrap_r  <= {WRAP_WIDTH{1'b0}};
            tc_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            lo_r    <= lo_s;
            hi_r    <= hi_s;
            out_r   <= out_s;
            wrap_r  <= wrap_s;
            tc_r    <= tc_s;
            err_r   <= err_s;
        end
    end

endmodule

// File: tb/tb_bounded_down_counter.sv
// Table-driven bench for bounded_down_counter: expected records are queued when driven
// and compared after the edge; a second instance with a 2-bit wrap counter checks saturation.
module tb_bounded_down_counter;

    logic        clk, rst, en, cfg_valid;
    logic [31:0] cfg_lower, cfg_upper;
    logic        cfg_ready, cfg_error, tc;
    logic [31:0] out;
    logic [15:0] wrap_cnt;
    logic        cfg_ready2, cfg_error2, tc2;
    logic [31:0] out2;
    logic [1:0]  wrap_cnt2;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic        en;
        logic        cv;
        logic [31:0] lo;
        logic [31:0] up;
        logic [31:0] out;
        logic        tc;
        logic        err;
        logic        rdy;
        int          wrap;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    bounded_down_counter dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cfg_error(cfg_error),
        .out(out), .tc(tc), .wrap_cnt(wrap_cnt)
    );

    bounded_down_counter #(.WRAP_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_lower(cfg_lower), .cfg_upper(cfg_upper), .cfg_error(cfg_error2),
        .out(out2), .tc(tc2), .wrap_cnt(wrap_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic void add(input logic e, input logic v, input logic [31:0] lo,
                                input logic [31:0] up, input logic [31:0] o, input logic t,
                                input logic er, input logic rd, input int w);
        vec_t x;
        x.en = e; x.cv = v; x.lo = lo; x.up = up;
        x.out = o; x.tc = t; x.err = er; x.rdy = rd; x.wrap = w;
        vecs.push_back(x);
    endfunction

    initial begin
        vec_t e;
        // Idle after reset, then a full default countdown with one wrap.
        add(1'b0, 1'b0, 32'd0, 32'd0, 32'd15, 1'b0, 1'b0, 1'b1, 0);
        add(1'b0, 1'b0, 32'd0, 32'd0, 32'd15, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 1; k <= 17; k++)
            add(1'b1, 1'b0, 32'd0, 32'd0, (k <= 15) ? 32'(15 - k) : ((k == 16) ? 32'd15 : 32'd14),
                (k == 16), 1'b0, 1'b1, (k >= 16) ? 1 : 0);
        for (int k = 1; k <= 5; k++)
            add(1'b1, 1'b0, 32'd0, 32'd0, 32'(14 - k), 1'b0, 1'b0, 1'b1, 1);
        // Accept 3/6 while running at 9; settle cycle, enable gap, wrap to 6.
        add(1'b1, 1'b1, 32'd3, 32'd6, 32'd6, 1'b0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd6, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd5, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd4, 1'b0, 1'b0, 1'b1, 0);
        add(1'b0, 1'b0, 32'd0, 32'd0, 32'd4, 1'b0, 1'b0, 1'b1, 0);
        add(1'b0, 1'b0, 32'd0, 32'd0, 32'd4, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd6, 1'b1, 1'b0, 1'b1, 1);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd5, 1'b0, 1'b0, 1'b1, 1);
        // Rejected 9/2: one error pulse, counting continues on 3/6.
        add(1'b1, 1'b1, 32'd9, 32'd2, 32'd4, 1'b0, 1'b1, 1'b1, 1);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1, 1);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd6, 1'b1, 1'b0, 1'b1, 2);
        // Equal bounds 7/7: tc and wrap every enabled cycle.
        add(1'b0, 1'b1, 32'd7, 32'd7, 32'd7, 1'b0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd7, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 1; k <= 4; k++)
            add(1'b1, 1'b0, 32'd0, 32'd0, 32'd7, 1'b1, 1'b0, 1'b1, k);
        add(1'b0, 1'b0, 32'd0, 32'd0, 32'd7, 1'b0, 1'b0, 1'b1, 4);
        // Bounds 0/1 for twelve cycles to saturate the narrow wrap counter.
        add(1'b0, 1'b1, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 0);
        add(1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1, 0);
        for (int k = 1; k <= 12; k++)
            add(1'b1, 1'b0, 32'd0, 32'd0, (k % 2 == 1) ? 32'd0 : 32'd1, (k % 2 == 0),
                1'b0, 1'b1, k / 2);
        add(1'b0, 1'b1, 32'd0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 0);
        // Offer ignored while not ready, then config beats a simultaneous enable.
        add(1'b1, 1'b1, 32'd2, 32'd5, 32'd1, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b1, 32'd2, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd5, 1'b0, 1'b0, 1'b1, 0);
        add(1'b1, 1'b0, 32'd0, 32'd0, 32'd4, 1'b0, 1'b0, 1'b1, 0);

        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_lower = 32'd0; cfg_upper = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 64'd15);
        chk("rst_tc", tc, 64'd0);
        chk("rst_err", cfg_error, 64'd0);
        chk("rst_wrap", wrap_cnt, 64'd0);
        chk("rst_rdy", cfg_ready, 64'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            en = vecs[i].en; cfg_valid = vecs[i].cv;
            cfg_lower = vecs[i].lo; cfg_upper = vecs[i].up;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_out", i), out, e.out);
            chk($sformatf("v%0d_tc", i), tc, e.tc);
            chk($sformatf("v%0d_err", i), cfg_error, e.err);
            chk($sformatf("v%0d_rdy", i), cfg_ready, e.rdy);
            chk($sformatf("v%0d_wrap", i), wrap_cnt, 64'(e.wrap));
            chk($sformatf("v%0d_wrap2", i), wrap_cnt2, 64'((e.wrap > 3) ? 3 : e.wrap));
        end

        // Asynchronous reset between edges while counting at 4.
        #2;
        rst = 1'b0;
        #1;
        chk("async_out", out, 64'd15);
        chk("async_tc", tc, 64'd0);
        chk("async_wrap", wrap_cnt, 64'd0);
        chk("async_rdy", cfg_ready, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out", out, 64'd14);
        chk("post_rst_wrap", wrap_cnt, 64'd0);
        en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
